// File: rtl/div_by_five_pkg.sv
// Shared types for the divide-by-five arbiter slice.
package div_by_five_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: first valid requester at or above i_ptr, wrapping.
module rr_priority_picker #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req_val,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_any,
    output logic [IDX_W-1:0]   o_grant_idx
);

    logic [IDX_W-1:0] w_idx;

    always_comb begin
        o_any       = 1'b0;
        o_grant_idx = '0;
        w_idx       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_idx = IDX_W'((32'(i_ptr) + i) % NUM_REQ);
            if (!o_any && i_req_val[w_idx]) begin
                o_any       = 1'b1;
                o_grant_idx = w_idx;
            end
        end
    end

endmodule

// File: rtl/div_by_five_arbiter.sv
// Shares one divide-by-five unit among NUM_REQ requesters, one transaction in flight.
module div_by_five_arbiter
    import div_by_five_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned WIDTH   = DEFAULT_WIDTH,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       i_req_val,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_msg,
    output logic [NUM_REQ-1:0]       o_req_rdy,
    output logic [NUM_REQ-1:0]       o_resp_val,
    output logic [NUM_REQ*WIDTH-1:0] o_resp_msg,
    input  logic [NUM_REQ-1:0]       i_resp_rdy,
    output logic                     o_unit_in_val,
    output logic [WIDTH-1:0]         o_unit_in_msg,
    input  logic                     i_unit_in_rdy,
    input  logic                     i_unit_out_val,
    input  logic [WIDTH-1:0]         i_unit_out_msg,
    output logic                     o_unit_out_rdy
);

    arb_state_t       r_state;
    arb_state_t       w_next_state;
    logic [IDX_W-1:0] r_grant_id;
    logic [IDX_W-1:0] r_ptr;
    logic [WIDTH-1:0] r_op;
    logic [WIDTH-1:0] r_res;

    logic             w_any;
    logic [IDX_W-1:0] w_grant_idx;
    logic             w_req_fire;
    logic             w_resp_fire;
    logic [IDX_W-1:0] w_ptr_next;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_req_val   (i_req_val),
        .i_ptr       (r_ptr),
        .o_any       (w_any),
        .o_grant_idx (w_grant_idx)
    );

    // The picker only selects a lane whose req_val is set, so rdy implies a handshake.
    assign w_req_fire  = (r_state == IDLE) && w_any;
    assign w_resp_fire = (r_state == RESP) && i_resp_rdy[r_grant_id];
    assign w_ptr_next  = (r_grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_id + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_req_fire)     w_next_state = ISSUE;
            ISSUE:   if (i_unit_in_rdy)  w_next_state = WAIT;
            WAIT:    if (i_unit_out_val) w_next_state = RESP;
            RESP:    if (w_resp_fire)    w_next_state = IDLE;
            default:                     w_next_state = IDLE;
        endcase
    end

    always_comb begin
        o_req_rdy      = '0;
        o_resp_val     = '0;
        o_unit_in_val  = 1'b0;
        o_unit_in_msg  = '0;
        o_unit_out_rdy = 1'b0;
        case (r_state)
            IDLE:    if (w_any) o_req_rdy[w_grant_idx] = 1'b1;
            ISSUE: begin
                o_unit_in_val = 1'b1;
                o_unit_in_msg = r_op;
            end
            WAIT:    o_unit_out_rdy = 1'b1;
            RESP:    o_resp_val[r_grant_id] = 1'b1;
            default: ;
        endcase
    end

    // Every response lane carries the result; only the owner's valid is raised.
    assign o_resp_msg = {NUM_REQ{r_res}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_id <= '0;
            r_ptr      <= '0;
            r_op       <= '0;
            r_res      <= '0;
        end else begin
            if (w_req_fire) begin
                r_grant_id <= w_grant_idx;
                r_op       <= i_req_msg[w_grant_idx*WIDTH +: WIDTH];
            end
            if ((r_state == WAIT) && i_unit_out_val) begin
                r_res <= i_unit_out_msg;
            end
            if (w_resp_fire) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

endmodule

// File: doc/div_by_five_arbiter.md
# div_by_five_arbiter

Round-robin arbiter and sequencer that shares one divide-by-five unit among `NUM_REQ` requesters. It accepts one request at a time over per-requester val/rdy ports and issues it to the unit's input handshake. It collects the unit's result and returns it on the originating requester's response port. It sits between the requester-side fabric and the single divide-by-five datapath/control pair.

## Interface
- `NUM_REQ`, default 4: number of requesters, at least 2.
- `WIDTH`, default 8: operand/result width in bits.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_val`  in  NUM_REQ  per-requester request valid.
- `req_msg`  in  NUM_REQ×WIDTH  per-requester operand.
- `req_rdy`  out  NUM_REQ  per-requester request ready.
- `resp_val`  out  NUM_REQ  per-requester response valid.
- `resp_msg`  out  NUM_REQ×WIDTH  per-requester result. All lanes carry the result register.
- `resp_rdy`  in  NUM_REQ  per-requester response ready.
- `unit_in_val`  out  1  operand valid to the unit.
- `unit_in_msg`  out  WIDTH  operand to the unit.
- `unit_in_rdy`  in  1  unit ready to accept an operand.
- `unit_out_val`  in  1  unit result valid.
- `unit_out_msg`  in  WIDTH  unit result.
- `unit_out_rdy`  out  1  arbiter ready to accept the result.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Registers:
  - `grant_id` (clog2(NUM_REQ) bits): current owner.
  - `ptr` (same width): highest-priority index.
  - `op_reg` (WIDTH): captured operand.
  - `res_reg` (WIDTH): captured result.
- IDLE:
  - Select the first index with `req_val` set, searching from `ptr` upward and wrapping modulo NUM_REQ.
  - If any is found, drive `req_rdy[g]=1` for that index only, the same cycle.
  - On that handshake, latch `op_reg=req_msg[g]` and `grant_id=g`, then go to ISSUE.
  - With no valid request, stay in IDLE with all `req_rdy` at 0.
- ISSUE:
  - Drive `unit_in_val=1` and `unit_in_msg=op_reg`.
  - When `unit_in_rdy=1`, go to WAIT.
  - `unit_in_val` stays high until accepted.
- WAIT:
  - Drive `unit_out_rdy=1`.
  - When `unit_out_val=1`, latch `res_reg=unit_out_msg` and go to RESP.
- RESP:
  - Drive `resp_val[grant_id]=1`. All other `resp_val` bits are 0.
  - When `resp_rdy[grant_id]=1`, set `ptr=(grant_id+1) mod NUM_REQ` and go to IDLE.
  - `resp_rdy` of non-granted lanes is ignored.
- Only one transaction is in flight. `req_rdy` is 0 in every state except IDLE.
- `ptr` wrap: when `grant_id=NUM_REQ-1`, the next `ptr` is 0.
- A requester that drops `req_val` before its grant simply loses that arbitration cycle. No state changes.
- `res_reg` is passed through unmodified; the arbiter performs no arithmetic.
- Reset (including mid-transaction):
  - State goes to IDLE. `ptr`, `grant_id`, `op_reg` and `res_reg` go to 0. The in-flight transaction is dropped.
  - The unit shares `rst`, so nothing is stranded in it.
- Output reset values: all `req_rdy` 0, all `resp_val` 0, `resp_msg` 0, `unit_in_val` 0, `unit_in_msg` 0, `unit_out_rdy` 0.

## Timing
- All outputs are decoded from the registered state and registers.
- The only combinational input-to-output path is `req_val` → `req_rdy` in IDLE, through the round-robin pick.
- Minimum occupancy with the unit answering in L cycles after acceptance, all handshakes immediately ready:
  - cycle 0: request accepted
  - cycle 1: issue
  - cycle 1+L: result captured
  - cycle 2+L: `resp_val` high
  - cycle 3+L: back in IDLE, next request can be accepted
- Back-to-back throughput: one transaction per 3+L cycles.
- A stalled `resp_rdy` holds RESP indefinitely. `resp_msg` stays stable while `resp_val` is high.

## Structure
- Shared package `div_by_five_pkg`:
  - state enum `arb_state_t` (IDLE, ISSUE, WAIT, RESP), 2 bits.
  - `WIDTH` default constant.
- Sub-module `rr_priority_picker`:
  - Purely combinational.
  - Inputs: `req_val[NUM_REQ]`, `ptr`.
  - Outputs: `any`, `grant_idx`.
  - Arbiter instantiates it once.

## Test plan
- Single request: req 2 sends 25; stub unit with L=1 returns 5 → `resp_val[2]` high at cycle 3 with `resp_msg=5`, all other `resp_val` 0, `ptr=3` afterward.
- All four requesters valid continuously from reset → grants in order 0,1,2,3,0, one per transaction; no requester is granted twice before all others are served.
- Wrap: `ptr=3`, requests on 1 and 3 → 3 granted first, then 1; `ptr` ends at 2.
- Backpressure:
  - `unit_in_rdy` held 0 for 5 cycles → `unit_in_val` and `unit_in_msg` stable throughout.
  - `resp_rdy[0]` held 0 for 4 cycles → `resp_val[0]` and `resp_msg` stable; `req_rdy` all 0.
- `rst` asserted in WAIT → next cycle state is IDLE, all outputs at reset values, `ptr=0`; a new request on 1 proceeds normally.
- Requester drops `req_val` in the same cycle that another asserts → no `req_rdy` to the dropped lane; the asserting lane is granted per `ptr`.
